i2s_tx_serializer: RTL and testbench
====================================

Name: i2s_tx_serializer

Overview:
Parametrised audio transmit serializer for the DAC path. It accepts one parallel frame of NUM_CH samples through a valid/ready handshake and generates SCLK and LRCK from in_clk using an internal divider. Samples are shifted out MSB-first in either I2S (one-bit delay) or left-justified format. A one-frame holding buffer decouples the sample producer from the serial timing, and the block flags an underrun when no new frame is ready.

Parameters:
DATA_W, 16, sample width in bits (1..32)
SLOT_W, 16, bits per channel slot; must be >= DATA_W; unused LSB bits are transmitted as 0
NUM_CH, 2, channels per frame (2, 4 or 8); FRAME_BITS = NUM_CH*SLOT_W
SCLK_DIV, 4, in_clk cycles per SCLK half-period (>=1); SCLK period = 2*SCLK_DIV in_clk cycles

Ports:
in_clk  input  1  system clock; all logic is on its rising edge
reset  input  1  asynchronous, active-high
enable  input  1  run serial output; when low, serial state is held idle
mode  input  1  0 = I2S (one-bit delay), 1 = left-justified; sampled at frame boundary
in_data  input  NUM_CH*DATA_W  channel k at [k*DATA_W +: DATA_W]; ch0 is sent first
in_valid  input  1  in_data is valid
in_ready  output  1  holding buffer is empty
sclk  output  1  serial bit clock
lrck  output  1  word select / frame sync
sdata  output  1  serial data; changes only on SCLK falling edges
frame_start  output  1  one-cycle pulse at each frame load
underrun  output  1  one-cycle pulse when a frame load finds no data

Behaviour:
- Reset (asynchronous) values:
  - sclk, lrck, sdata, frame_start and underrun are 0.
  - Holding buffer is empty, so in_ready = 1.
  - Divider, bit counter and shifter are 0; the latched mode is 0.
- Handshake: a transfer occurs on a cycle with in_valid & in_ready. Data is copied into the buffer, and the buffer becomes full on the next cycle. in_ready = !full.
- Divider:
  - div_cnt counts 0..SCLK_DIV-1.
  - At SCLK_DIV-1, sclk toggles and div_cnt wraps to 0.
  - A 1->0 toggle is the "fall event".
- Bit counter: bit_cnt counts 0..FRAME_BITS-1 and advances on every fall event, wrapping from FRAME_BITS-1 to 0.
- Load event: the fall event on which bit_cnt wraps to 0, plus the first fall event after enable rises.
  - If the buffer is full: shifter <= buffer, buffer is emptied, frame_start pulses.
  - If the buffer is empty and this cycle is a transfer: in_data is loaded directly into the shifter (bypass), with no underrun.
  - Otherwise: shifter <= all zeros, and both underrun and frame_start pulse.
  - mode is latched at each load event; a mode change mid-frame takes effect on the next frame.
- Slot layout: each slot carries its DATA_W sample MSB-first, followed by SLOT_W-DATA_W zeros.
- lrck:
  - lrck = 1 when bit_cnt >= FRAME_BITS/2, else 0.
  - With NUM_CH=2 this gives left = 0, right = 1. With TDM it is a 50% frame clock.
  - lrck is registered and updates on the fall event.
- Left-justified mode: sdata = the current shifter MSB; the MSB of ch0 coincides with lrck falling to 0.
- I2S mode:
  - sdata is delayed by one SCLK through an extra register.
  - The MSB of ch0 appears one SCLK after the lrck edge.
  - At bit_cnt 0, sdata carries the LSB of the last slot of the previous frame (0 after reset or idle).
- enable low:
  - Divider and bit_cnt are cleared; sclk, lrck and sdata are driven 0; the delay register is cleared.
  - The handshake stays active, so one frame can be pre-buffered.
- Reset mid-frame: takes effect immediately and discards any buffered frame.

Optional Feature:
I2S_TX_HOLD_LAST_EN
- Defined: on underrun, the shifter reloads the last transmitted frame (held in a copy register) instead of zeros. underrun still pulses.
- Undefined: the copy register is absent, and underrun frames are all zeros.

Test Plan:
Common configuration: DATA_W=16, SLOT_W=16, NUM_CH=2, SCLK_DIV=2.
- Reset check: assert reset mid-run -> sclk, lrck, sdata, frame_start and underrun all read 0 immediately; in_ready = 1.
- Left-justified frame: mode=1, prebuffer L=16'hA5C3, R=16'h1234, then raise enable -> across 32 SCLK rising edges sdata = A5C3 then 1234, MSB-first; lrck is 0 for the first 16 bits and 1 for the next 16; one frame_start pulse.
- I2S frame: same data with mode=0 -> first rising edge after lrck falls samples 0; the next 16 edges carry A5C3; the LSB of 1234 appears at bit_cnt 0 of the following frame.
- Underrun: supply no second frame -> underrun pulses at the second load event. The frame is all zeros without I2S_TX_HOLD_LAST_EN, and repeats A5C3/1234 with it.
- Backpressure: hold in_valid with 3 distinct frames -> in_ready drops after the first transfer and rises on the cycle after each load; all 3 frames are sent in order with no underrun.
- Padding: DATA_W=24, SLOT_W=32, L=24'h800001 -> slot bits = 1, 22 zeros, 1, then 8 zeros.

Source files
------------

// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - I2S / left-justified audio TX serializer with one-frame holding buffer.
// Optional: define I2S_TX_HOLD_LAST_EN to repeat the last frame on underrun instead of sending zeros.
module i2s_tx_serializer #(
    parameter int DATA_W   = 16,
    parameter int SLOT_W   = 16,
    parameter int NUM_CH   = 2,
    parameter int SCLK_DIV = 4
) (
    input  logic                     in_clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     mode,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     sclk,
    output logic                     lrck,
    output logic                     sdata,
    output logic                     frame_start,
    output logic                     underrun
);
    localparam int FRAME_BITS = NUM_CH * SLOT_W;
    localparam int DIV_W      = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BC_W       = $clog2(FRAME_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(FRAME_BITS - 1);
    localparam logic [BC_W-1:0]  BC_HALF  = BC_W'(FRAME_BITS / 2);

    logic [DIV_W-1:0]      r_div_cnt;
    logic                  r_sclk;
    logic [BC_W-1:0]       r_bit_cnt;
    logic                  r_lrck;
    logic [FRAME_BITS-1:0] r_shift;
    logic [FRAME_BITS-1:0] r_buf;
    logic                  r_full;
    logic                  r_mode;
    logic                  r_sdata;
    logic                  r_dly;
    logic                  r_frame_start;
    logic                  r_underrun;
    logic                  r_armed;
`ifdef I2S_TX_HOLD_LAST_EN
    logic [FRAME_BITS-1:0] r_last;
`endif

    logic                  w_xfer;
    logic                  w_fall;
    logic                  w_load;
    logic                  w_underrun;
    logic                  w_mode;
    logic [BC_W-1:0]       w_bit_next;
    logic [FRAME_BITS-1:0] w_fmt;
    logic [FRAME_BITS-1:0] w_shift_next;

    // Places each channel MSB-aligned in its slot, ch0 in the top slot so it leaves first.
    function automatic logic [FRAME_BITS-1:0] f_format(input logic [NUM_CH*DATA_W-1:0] d);
        logic [FRAME_BITS-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_CH; k++)
            v[FRAME_BITS-1-k*SLOT_W -: DATA_W] = d[k*DATA_W +: DATA_W];
        return v;
    endfunction

    assign w_fmt      = f_format(in_data);
    assign w_xfer     = in_valid & ~r_full;
    assign w_fall     = enable & r_sclk & (r_div_cnt == DIV_LAST);
    assign w_load     = w_fall & (r_armed | (r_bit_cnt == BC_LAST));
    assign w_mode     = w_load ? mode : r_mode;
    assign w_bit_next = w_load ? '0 : r_bit_cnt + 1'b1;

    always_comb begin
        w_shift_next = {r_shift[FRAME_BITS-2:0], 1'b0};
        w_underrun   = 1'b0;
        if (w_load) begin
            if (r_full) begin
                w_shift_next = r_buf;
            end else if (w_xfer) begin
                w_shift_next = w_fmt;
            end else begin
                w_underrun = 1'b1;
`ifdef I2S_TX_HOLD_LAST_EN
                w_shift_next = r_last;
`else
                w_shift_next = '0;
`endif
            end
        end
    end

    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            r_div_cnt     <= '0;
            r_sclk        <= 1'b0;
            r_bit_cnt     <= '0;
            r_lrck        <= 1'b0;
            r_shift       <= '0;
            r_buf         <= '0;
            r_full        <= 1'b0;
            r_mode        <= 1'b0;
            r_sdata       <= 1'b0;
            r_dly         <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            r_armed       <= 1'b1;
`ifdef I2S_TX_HOLD_LAST_EN
            r_last        <= '0;
`endif
        end else begin
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;

            // A load with an empty buffer and a live transfer bypasses straight into the shifter.
            if (w_xfer && !w_load) begin
                r_buf  <= w_fmt;
                r_full <= 1'b1;
            end else if (w_load) begin
                r_full <= 1'b0;
            end

            if (!enable) begin
                r_div_cnt <= '0;
                r_sclk    <= 1'b0;
                r_bit_cnt <= '0;
                r_lrck    <= 1'b0;
                r_sdata   <= 1'b0;
                r_dly     <= 1'b0;
                r_armed   <= 1'b1;
            end else begin
                if (r_div_cnt == DIV_LAST) begin
                    r_div_cnt <= '0;
                    r_sclk    <= ~r_sclk;
                end else begin
                    r_div_cnt <= r_div_cnt + 1'b1;
                end

                if (w_fall) begin
                    r_armed   <= 1'b0;
                    r_bit_cnt <= w_bit_next;
                    r_lrck    <= (w_bit_next >= BC_HALF);
                    r_shift   <= w_shift_next;
                    // r_dly always tracks the left-justified bit; I2S emits it one SCLK later.
                    r_dly     <= w_shift_next[FRAME_BITS-1];
                    r_sdata   <= w_mode ? w_shift_next[FRAME_BITS-1] : r_dly;
                    if (w_load) begin
                        r_mode        <= mode;
                        r_frame_start <= 1'b1;
                        r_underrun    <= w_underrun;
`ifdef I2S_TX_HOLD_LAST_EN
                        if (!w_underrun)
                            r_last <= w_shift_next;
`endif
                    end
                end
            end
        end
    end

    assign in_ready    = ~r_full;
    assign sclk        = r_sclk;
    assign lrck        = r_lrck;
    assign sdata       = r_sdata;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb/tb_i2s_tx_serializer.sv - scoreboard bench for i2s_tx_serializer (honours I2S_TX_HOLD_LAST_EN).
module tb_i2s_tx_serializer;
    localparam int DW  = 16;
    localparam int SW  = 16;
    localparam int NC  = 2;
    localparam int DIV = 2;
    localparam int FB  = NC * SW;

    logic        in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    logic        reset = 1'b1, enable = 1'b0, mode = 1'b0, in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, sclk, lrck, sdata, frame_start, underrun;

    logic        p_enable = 1'b0, p_mode = 1'b1, p_in_valid = 1'b0;
    logic [47:0] p_in_data = '0;
    logic        p_in_ready, p_sclk, p_lrck, p_sdata, p_frame_start, p_underrun;

    i2s_tx_serializer #(.DATA_W(DW), .SLOT_W(SW), .NUM_CH(NC), .SCLK_DIV(DIV)) dut (
        .in_clk(in_clk), .reset(reset), .enable(enable), .mode(mode),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sclk(sclk), .lrck(lrck), .sdata(sdata),
        .frame_start(frame_start), .underrun(underrun)
    );

    i2s_tx_serializer #(.DATA_W(24), .SLOT_W(32), .NUM_CH(2), .SCLK_DIV(DIV)) dut_pad (
        .in_clk(in_clk), .reset(reset), .enable(p_enable), .mode(p_mode),
        .in_data(p_in_data), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .sclk(p_sclk), .lrck(p_lrck), .sdata(p_sdata),
        .frame_start(p_frame_start), .underrun(p_underrun)
    );

    int          checks = 0, errors = 0;
    int          fs_cnt = 0, ur_cnt = 0, edge_n = 0;
    logic [1:0]  exp_q[$];
    logic [31:0] feed_q[$];
    logic        prev_sclk = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Producer: holds in_valid while frames are queued; in_ready is stable between edges.
    always @(negedge in_clk) begin
        if (feed_q.size() > 0) begin
            in_valid = 1'b1;
            in_data  = feed_q[0];
            if (in_ready && !reset)
                void'(feed_q.pop_front());
        end else begin
            in_valid = 1'b0;
        end
    end

    // Monitor: pops one expected {lrck, sdata} per SCLK rising edge.
    always @(negedge in_clk) begin
        logic [1:0] e;
        if (enable && !reset) begin
            if (frame_start) fs_cnt++;
            if (underrun)    ur_cnt++;
            if (sclk && !prev_sclk && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("edge %0d lrck/sdata", edge_n), {62'd0, lrck, sdata}, {62'd0, e});
                edge_n++;
            end
        end
        prev_sclk = sclk;
    end

    task automatic run_test(input int nf, input int nu, input bit m, input bit directed);
        logic [31:0] fr[$];
        bit          stream[$];
        logic [31:0] f, smp;
        int          fs0, ur0, slot, pos;
        enable = 1'b0;
        mode   = m;
        repeat (3) @(negedge in_clk);
        for (int i = 0; i < nf; i++) begin
            f = (directed && i == 0) ? 32'h1234_A5C3 : $urandom();
            fr.push_back(f);
            feed_q.push_back(f);
        end
        for (int i = 0; i < nu; i++) begin
`ifdef I2S_TX_HOLD_LAST_EN
            fr.push_back(fr[nf-1]);
`else
            fr.push_back(32'h0);
`endif
        end
        foreach (fr[i]) begin
            for (int b = 0; b < FB; b++) begin
                slot = b / SW;
                pos  = b % SW;
                smp  = fr[i] >> (slot * DW);
                stream.push_back(smp[DW-1-pos]);
            end
        end
        // The edge before the first frame is idle.
        exp_q.push_back(2'b00);
        for (int n = 0; n < stream.size(); n++)
            exp_q.push_back({((n % FB) >= FB/2) ? 1'b1 : 1'b0,
                             m ? stream[n] : ((n == 0) ? 1'b0 : stream[n-1])});
        for (int c = 0; c < 50; c++) begin
            @(negedge in_clk);
            if (!in_ready) break;
        end
        check("prebuffer in_ready", {63'd0, in_ready}, 64'd0);
        fs0    = fs_cnt;
        ur0    = ur_cnt;
        enable = 1'b1;
        for (int c = 0; c < 4000 && exp_q.size() > 0; c++)
            @(negedge in_clk);
        enable = 1'b0;
        check("expected edges left", exp_q.size(), 0);
        exp_q.delete();
        check("frame_start count", fs_cnt - fs0, nf + nu);
        check("underrun count", ur_cnt - ur0, nu);
        check("frames accepted", feed_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [23:0] r24;
        logic [63:0] got;
        int          k;
        logic        pp;

        #12;
        check("reset sclk", {63'd0, sclk}, 0);
        check("reset lrck", {63'd0, lrck}, 0);
        check("reset sdata", {63'd0, sdata}, 0);
        check("reset frame_start", {63'd0, frame_start}, 0);
        check("reset underrun", {63'd0, underrun}, 0);
        check("reset in_ready", {63'd0, in_ready}, 1);
        @(negedge in_clk);
        #2 reset = 1'b0;

        run_test(1, 1, 1'b1, 1'b1);
        run_test(1, 1, 1'b0, 1'b1);
        run_test(3, 0, 1'($urandom_range(1)), 1'b0);
        for (int t = 0; t < 4; t++)
            run_test($urandom_range(3, 1), $urandom_range(1), 1'($urandom_range(1)), 1'b0);

        // Asynchronous reset mid-frame with a frame still buffered.
        mode = 1'b1;
        feed_q.push_back($urandom());
        feed_q.push_back($urandom());
        feed_q.push_back($urandom());
        enable = 1'b1;
        repeat (45) @(negedge in_clk);
        #2 reset = 1'b1;
        #1;
        check("midrun reset sclk", {63'd0, sclk}, 0);
        check("midrun reset lrck", {63'd0, lrck}, 0);
        check("midrun reset sdata", {63'd0, sdata}, 0);
        check("midrun reset frame_start", {63'd0, frame_start}, 0);
        check("midrun reset underrun", {63'd0, underrun}, 0);
        check("midrun reset in_ready", {63'd0, in_ready}, 1);
        feed_q.delete();
        enable = 1'b0;
        @(negedge in_clk);
        #2 reset = 1'b0;
        repeat (2) @(negedge in_clk);
        check("post reset in_ready", {63'd0, in_ready}, 1);

        run_test(2, 1, 1'b0, 1'b0);

        // Slot padding: DATA_W=24 in a 32-bit slot.
        r24        = 24'($urandom());
        p_in_data  = {r24, 24'h800001};
        p_in_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge in_clk);
            if (!p_in_ready) break;
        end
        p_in_valid = 1'b0;
        p_enable   = 1'b1;
        got = '0;
        k   = 0;
        pp  = 1'b0;
        for (int c = 0; c < 2000 && k < 65; c++) begin
            @(negedge in_clk);
            if (p_sclk && !pp) begin
                if (k > 0) got[64-k] = p_sdata;
                k++;
            end
            pp = p_sclk;
        end
        p_enable = 1'b0;
        check("pad edge count", k, 65);
        check("pad slot L", {32'd0, got[63:32]}, 64'h8000_0100);
        check("pad slot R", {32'd0, got[31:0]}, {32'd0, r24, 8'h00});

        repeat (4) @(negedge in_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
